// File: rtl/mem_port_arbiter.sv
// Shares one memory word port between instruction fetch and load/store, with data priority and fetch anti-starvation.
// Optional performance counters are enabled by defining MEM_PORT_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_inst,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [4:0]        mem_rmem,
  output logic [3:0]        mem_wmem,
  output logic [31:0]       mem_store_data,
  input  logic [31:0]       mem_load_data
`ifdef MEM_PORT_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_if_stall
`endif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // An ack always follows its grant by exactly one cycle, so the ack register doubles as the busy flag.
  logic             if_ack_q, d_ack_q;
  logic [31:0]      if_inst_q, d_rdata_q;
  logic             if_err_q, d_err_q;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic if_elig, d_elig, if_gnt, d_gnt;
  logic if_err_c, d_err_c;
  logic [3:0] d_lanes;

  assign if_elig = if_req & ~if_ack_q;
  assign d_elig  = d_req & ~d_ack_q;
  // Grants are suppressed while reset is asserted so no write reaches the memory.
  assign if_gnt  = rst_n & if_elig & (~d_elig | (starve_q == CNT_MAX));
  assign d_gnt   = rst_n & d_elig & ~if_gnt;

  assign if_err_c = (|if_addr[1:0]) | (|if_addr[31:ADDR_W+2]);
  assign d_err_c  = (d_size == 2'b11)
                  | ((d_size == 2'b01) & d_addr[0])
                  | ((d_size == 2'b10) & (|d_addr[1:0]))
                  | (|d_addr[31:ADDR_W+2]);
  assign d_lanes  = lane_mask(d_size, d_addr[1:0]);

  always_comb begin
    mem_addr       = '0;
    mem_rmem       = '0;
    mem_wmem       = '0;
    mem_store_data = '0;
    if (if_gnt) begin
      mem_addr = if_addr[ADDR_W+1:2];
      if (!if_err_c) mem_rmem = 5'b01111;
    end else if (d_gnt) begin
      mem_addr = d_addr[ADDR_W+1:2];
      if (!d_err_c) begin
        if (d_we) begin
          mem_wmem       = d_lanes;
          mem_store_data = d_wdata;
        end else if (d_size == 2'b10) begin
          mem_rmem = 5'b01111;
        end else begin
          mem_rmem = {~d_unsigned, d_lanes};
        end
      end
    end
  end

  always_comb begin
    starve_d = '0;
    if (if_elig && d_gnt) starve_d = sat_inc(starve_q);
  end

  // Response stage: register the memory result seen during the grant cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_ack_q  <= 1'b0;
      d_ack_q   <= 1'b0;
      if_inst_q <= '0;
      if_err_q  <= 1'b0;
      d_rdata_q <= '0;
      d_err_q   <= 1'b0;
      starve_q  <= '0;
    end else begin
      if_ack_q <= if_gnt;
      d_ack_q  <= d_gnt;
      starve_q <= starve_d;
      if (if_gnt) begin
        if_inst_q <= if_err_c ? 32'h0 : mem_load_data;
        if_err_q  <= if_err_c;
      end
      if (d_gnt) begin
        d_rdata_q <= (d_err_c | d_we) ? 32'h0 : mem_load_data;
        d_err_q   <= d_err_c;
      end
    end
  end

  assign if_ack  = if_ack_q;
  assign if_inst = if_inst_q;
  assign if_err  = if_err_q;
  assign d_ack   = d_ack_q;
  assign d_rdata = d_rdata_q;
  assign d_err   = d_err_q;

`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_if_grants_q, perf_d_grants_q, perf_if_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_if_grants_q <= '0;
      perf_d_grants_q  <= '0;
      perf_if_stall_q  <= '0;
    end else begin
      if (if_gnt) perf_if_grants_q <= perf_if_grants_q + 32'd1;
      if (d_gnt) perf_d_grants_q <= perf_d_grants_q + 32'd1;
      if (if_elig && !if_gnt) perf_if_stall_q <= perf_if_stall_q + 32'd1;
    end
  end

  assign perf_if_grants = perf_if_grants_q;
  assign perf_d_grants  = perf_d_grants_q;
  assign perf_if_stall  = perf_if_stall_q;
`endif

endmodule
